// File: rtl/ctrl_fsm_seq.sv
// Five-state fetch/decode/execute sequencer for the 8-bit datapath, with registered Z/C flags.
// Define CTRL_IRQ_EN to add the one-cycle IRQ vector-load state entered from a stalled FETCH.
module ctrl_fsm_seq #(
  parameter int unsigned IR_W        = 8,
  parameter int unsigned OP_W        = 4,
  parameter logic [1:0]  IRQ_VEC_SEL = 2'b10
) (
  input  logic                 CLK,
  input  logic                 CLB,
  input  logic [IR_W-1:0]      Instr,
  input  logic                 Z,
  input  logic                 C,
  input  logic                 IMemAck,
  input  logic                 Irq,
  output logic                 IMemReq,
  output logic                 LoadIR,
  output logic                 IncPC,
  output logic                 LoadPC,
  output logic                 LoadReg,
  output logic                 LoadAcc,
  output logic [1:0]           SelPC,
  output logic [1:0]           SelAcc,
  output logic [OP_W-1:0]      SelALU,
  output logic [IR_W-OP_W-1:0] RegSel,
  output logic                 Halted,
  output logic                 IllegalOp,
  output logic                 IrqAck
);

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
`ifdef CTRL_IRQ_EN
    S_IRQ,
`endif
    S_HALT
  } state_e;

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(4'h3);
  localparam logic [OP_W-1:0] OP_MRA  = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OP_MAR  = OP_W'(4'h5);
  localparam logic [OP_W-1:0] OP_JZR  = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_JZI  = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_JCR  = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_JCI  = OP_W'(4'hA);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(4'hB);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(4'hC);
  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(4'hD);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(4'hF);

  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_REG = 2'b10;
  localparam logic [1:0] ACC_IMM = 2'b11;
  localparam logic [1:0] PC_IMM  = 2'b00;
  localparam logic [1:0] PC_REG  = 2'b01;

  state_e          state_q, state_d;
  logic            zf_q, zf_d;
  logic            cf_q, cf_d;
  logic [OP_W-1:0] opcode;
  logic            jmp_flag;
  logic            jmp_reg;

  // Instr comes straight from the IR register, so decoding it here keeps outputs Moore.
  assign opcode   = Instr[IR_W-1 -: OP_W];
  assign RegSel   = Instr[IR_W-OP_W-1:0];
  assign jmp_flag = (opcode == OP_JZR || opcode == OP_JZI) ? zf_q : cf_q;
  assign jmp_reg  = (opcode == OP_JZR || opcode == OP_JCR);

`ifndef CTRL_IRQ_EN
  logic unused_irq;
  assign unused_irq = Irq;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      state_q <= S_RST;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
    end
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (IMemAck) begin
          state_d = S_DECODE;
        end
`ifdef CTRL_IRQ_EN
        else if (Irq) begin
          state_d = S_IRQ;
        end
`endif
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = (opcode == OP_HALT) ? S_HALT : S_FETCH;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          zf_d = Z;
          cf_d = C;
        end
      end
`ifdef CTRL_IRQ_EN
      S_IRQ:    state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RST;
    endcase
  end

  always_comb begin
    IMemReq   = 1'b0;
    LoadIR    = 1'b0;
    IncPC     = 1'b0;
    LoadPC    = 1'b0;
    LoadReg   = 1'b0;
    LoadAcc   = 1'b0;
    SelPC     = PC_IMM;
    SelAcc    = ACC_ALU;
    SelALU    = '0;
    Halted    = 1'b0;
    IllegalOp = 1'b0;
    IrqAck    = 1'b0;
    unique case (state_q)
      S_FETCH:  IMemReq = 1'b1;
      S_DECODE: LoadIR  = 1'b1;
      S_EXEC: begin
        SelALU = opcode;
        case (opcode)
          OP_NOP: IncPC = 1'b1;
          OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: begin
            LoadAcc = 1'b1;
            SelAcc  = ACC_ALU;
            IncPC   = 1'b1;
          end
          OP_MRA: begin
            LoadAcc = 1'b1;
            SelAcc  = ACC_REG;
            IncPC   = 1'b1;
          end
          OP_MAR: begin
            LoadReg = 1'b1;
            IncPC   = 1'b1;
          end
          OP_LDI: begin
            LoadAcc = 1'b1;
            SelAcc  = ACC_IMM;
            IncPC   = 1'b1;
          end
          OP_JZR, OP_JZI, OP_JCR, OP_JCI: begin
            LoadPC = jmp_flag;
            IncPC  = ~jmp_flag;
            SelPC  = (jmp_flag && jmp_reg) ? PC_REG : PC_IMM;
          end
          OP_HALT: ;
          default: begin
            IncPC     = 1'b1;
            IllegalOp = 1'b1;
          end
        endcase
      end
`ifdef CTRL_IRQ_EN
      S_IRQ: begin
        LoadPC = 1'b1;
        SelPC  = IRQ_VEC_SEL;
        IrqAck = 1'b1;
      end
`endif
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/ctrl_fsm_seq.md
# ctrl_fsm_seq

Parametrised, multi-cycle instruction-sequencing controller for the 8-bit microprocessor datapath. It replaces the three-state fetch/execute controller with a five-state machine. The new machine adds an instruction-memory request/acknowledge handshake, registered Z/C flags, a true halt, illegal-opcode reporting and an optional interrupt entry. It drives the IR, PC, register-file, accumulator-mux and ALU-select controls of the existing datapath.

## Interface
- IR_W, 8, instruction width; opcode is Instr[IR_W-1:IR_W-OP_W]
- OP_W, 4, opcode width; must be ≥4 and < IR_W
- IRQ_VEC_SEL, 2'b10, SelPC code used to load the interrupt vector

Ports:
- CLK  in  1  clock, all state changes on rising edge
- CLB  in  1  reset; synchronous, active-high (1 = reset on next CLK edge)
- Instr  in  IR_W  instruction word from IR (valid from cycle after LoadIR)
- Z, C  in  1  ALU zero/carry of the current EXEC operation
- IMemAck  in  1  instruction memory has word on bus
- Irq  in  1  interrupt request, level (only with CTRL_IRQ_EN)
- IMemReq  out  1  instruction fetch request
- LoadIR, IncPC, LoadPC, LoadReg, LoadAcc  out  1  datapath strobes
- SelPC  out  2  00 immediate, 01 register, 10 IRQ vector
- SelAcc  out  2  accumulator source, same codes as existing datapath
- SelALU  out  OP_W  ALU function (= opcode in EXEC, 0 otherwise)
- RegSel  out  IR_W-OP_W  register index, = Instr low field
- Halted, IllegalOp, IrqAck  out  1  status

## Operation
- States: RST, FETCH, DECODE, EXEC, HALT (+ IRQ with macro).
- RST: all strobes 0, SelPC/SelAcc/SelALU 0; leaves to FETCH next cycle.
- FETCH: IMemReq=1; stays until IMemAck=1, then DECODE.
- DECODE: LoadIR=1 for exactly one cycle, then EXEC.
- EXEC (one cycle, then FETCH unless HALT):
  - 0 NOP: IncPC.
  - 1 ADD, 2 SUB: LoadAcc, SelAcc 00, IncPC; Zf<=Z, Cf<=C at cycle end.
  - 3 NOR, B SHL, C SHR: LoadAcc, SelAcc 00, IncPC; flags held.
  - 4 MOV R→A: LoadAcc, SelAcc 10, IncPC.
  - 5 MOV A→R: LoadReg, IncPC.
  - D LDI: LoadAcc, SelAcc 11, IncPC.
  - 6 JZ reg / 7 JZ imm / 8 JC reg / A JC imm: when the tested registered flag is 1, LoadPC=1, IncPC=0, SelPC 01 (reg) or 00 (imm). When the flag is 0, IncPC=1, LoadPC=0. The accumulator is never loaded.
  - F HALT: no strobes; next state HALT.
  - 9, E: treated as NOP plus IllegalOp=1 for that cycle.
- HALT: all strobes 0, Halted=1; exits only by reset.
- LoadPC and IncPC are never both 1. Flags Zf, Cf reset to 0.

## Timing
- Instruction latency = (FETCH cycles ≥1) + 1 + 1; with IMemAck tied high: 3 cycles/instruction.
- IMemReq drops in the cycle after IMemAck is sampled high.
- Outputs are Moore-decoded from state and the latched opcode. There are no combinational paths from Z/C to outputs.
- CLB=1 in any state: next state RST, flags cleared, all outputs 0 in the following cycle. Reset mid-FETCH abandons the request.
- RegSel follows Instr combinationally in all states.

## Configuration
- CTRL_IRQ_EN defined:
  - In FETCH, with Irq=1 and no IMemAck in the same cycle, the machine goes to the IRQ state.
  - IRQ lasts one cycle: LoadPC=1, SelPC=IRQ_VEC_SEL, IrqAck=1, then FETCH.
  - Irq is ignored in HALT.
  - IMemAck has priority when it coincides with Irq.
- CTRL_IRQ_EN undefined: no IRQ state, Irq unused, IrqAck tied 0.

## Test plan
- Reset: hold CLB=1 for 2 cycles, release → all outputs 0 and flags 0 for the first cycle, then IMemReq=1.
- Fetch stall: IMemAck low for 3 cycles then high → IMemReq high for 4 cycles, LoadIR exactly once after.
- ADD with Z=1, C=0 then JZ imm (opcode 7) → LoadPC=1, SelPC=00, IncPC=0. The following JC imm (opcode A) gives IncPC=1, LoadPC=0.
- Opcode 9 → IllegalOp pulse one cycle, IncPC=1, state returns to FETCH.
- HALT (opcode F) then toggle IMemAck/Irq for 10 cycles → Halted=1, no strobes; CLB=1 → RST.
- With CTRL_IRQ_EN: Irq=1 during stalled FETCH → one-cycle IrqAck, LoadPC=1, SelPC=10. Irq and IMemAck together → DECODE, no IrqAck.
